// File: rtl/sign_ext16_30_if.sv
// Bundles the data and mode signals of sign_ext16_30; clk and reset are not part of it.
// The bench drives the master side, and the DUT ports connect to the slave side.
interface sign_ext16_30_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 30
);
  logic [IN_W-1:0]  in;
  logic             zext;
  logic             shl2;
  logic             in_valid;
  logic [OUT_W-1:0] out;
  logic [OUT_W-1:0] q;
  logic             q_valid;

  modport master (
    output in, zext, shl2, in_valid,
    input  out, q, q_valid
  );

  modport slave (
    input  in, zext, shl2, in_valid,
    output out, q, q_valid
  );
endinterface

// File: rtl/sign_ext16_30.sv
// Sign extender with two outputs: a combinational sign-extended copy of in,
// and a one-cycle registered result that can be zero-extended and/or shifted left by 2.
module sign_ext16_30 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 30
) (
  output logic [OUT_W-1:0] out,
  input  logic [IN_W-1:0]  in,
  input  logic             clk,
  input  logic             reset,
  input  logic             zext,
  input  logic             shl2,
  input  logic             in_valid,
  output logic [OUT_W-1:0] q,
  output logic             q_valid
);

  generate
    if (IN_W < 1 || OUT_W <= IN_W) begin : g_bad_params
      $error("sign_ext16_30: need IN_W >= 1 and OUT_W > IN_W");
    end
  endgenerate

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] r;

  always_comb begin
    out = {{(OUT_W-IN_W){in[IN_W-1]}}, in};
  end

  // zext forces the fill bits to 0; the shift drops the top two bits of ext.
  always_comb begin
    ext = {{(OUT_W-IN_W){in[IN_W-1] & ~zext}}, in};
    r   = shl2 ? (ext << 2) : ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (in_valid) begin
      q       <= r;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_ext16_30.sv
// Self-checking bench for sign_ext16_30: directed boundary steps followed by a
// randomized full sweep of in, checked against an arithmetic reference model.
module tb_sign_ext16_30;
  localparam int IN_W  = 16;
  localparam int OUT_W = 30;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sign_ext16_30_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  sign_ext16_30 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .out      (bus.out),
    .in       (bus.in),
    .clk      (clk),
    .reset    (reset),
    .zext     (bus.zext),
    .shl2     (bus.shl2),
    .in_valid (bus.in_valid),
    .q        (bus.q),
    .q_valid  (bus.q_valid)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [OUT_W-1:0] exp_q;
  logic             exp_qv;

  // Reference: read in as a signed or unsigned integer, optionally multiply by 4,
  // then keep the low OUT_W bits.
  function automatic logic [OUT_W-1:0] ref_val(input logic [IN_W-1:0] v,
                                               input logic z, input logic s);
    longint x;
    logic [OUT_W-1:0] res;
    x = longint'(v);
    if (!z && x >= (longint'(1) << (IN_W-1))) x = x - (longint'(1) << IN_W);
    if (s) x = x * 4;
    res = x[OUT_W-1:0];
    return res;
  endfunction

  task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Drives one cycle of stimulus, checks out combinationally before the edge,
  // then checks q/q_valid against the model after the edge.
  task automatic step(input logic [IN_W-1:0] v, input logic z, input logic s,
                      input logic iv, input logic r);
    bus.in       = v;
    bus.zext     = z;
    bus.shl2     = s;
    bus.in_valid = iv;
    reset        = r;
    #2;
    check("out", bus.out, ref_val(v, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    if (r) begin
      exp_q  = '0;
      exp_qv = 1'b0;
    end else if (iv) begin
      exp_q  = ref_val(v, z, s);
      exp_qv = 1'b1;
    end else begin
      exp_qv = 1'b0;
    end
    check("q", bus.q, exp_q);
    check("q_valid", {{(OUT_W-1){1'b0}}, bus.q_valid}, {{(OUT_W-1){1'b0}}, exp_qv});
  endtask

  initial begin
    int unsigned off;
    logic [IN_W-1:0] v;

    bus.in = '0; bus.zext = 1'b0; bus.shl2 = 1'b0; bus.in_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, with in_valid high to confirm that reset takes priority.
    step(16'h1234, 1'b0, 1'b0, 1'b1, 1'b1);
    check("reset_q", bus.q, '0);

    step(16'd23,   1'b0, 1'b0, 1'b1, 1'b0);
    check("pos23_out", bus.out, 30'd23);
    step(16'hFFE9, 1'b0, 1'b0, 1'b1, 1'b0);
    check("neg23_out", bus.out, 30'h3FFFFFE9);

    step(16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("min_sign_q", bus.q, 30'h3FFF8000);
    step(16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    check("min_zext_q", bus.q, 30'h00008000);
    step(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("min_shl2_q", bus.q, 30'h3FFE0000);
    step(16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
    check("max_q", bus.q, 30'h00007FFF);
    step(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("zero_q", bus.q, '0);

    step(16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ones_shl2_q", bus.q, 30'h3FFFFFFC);
    step(16'h5555, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_q", bus.q, 30'h3FFFFFFC);

    // Reset mid-stream while out keeps tracking in, then the first capture after reset.
    step(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_out", bus.out, 30'h3FFFFFFF);
    step(16'h0042, 1'b1, 1'b1, 1'b1, 1'b0);
    check("post_rst_q", bus.q, 30'h00000108);

    // Full sweep over all input values, visited in a random order.
    off = $urandom;
    for (int unsigned i = 0; i < (1 << IN_W); i++) begin
      v = IN_W'(i * 40503 + off);
      step(v, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 255) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    miscompares++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end
endmodule
